// File: rtl/interrupt_arbiter_pkg.sv
// interrupt_pkg
//   Opcode constants and helpers shared by the interrupt arbiter slice.
//   - OP_BRK and the eight conditional-branch opcodes
//   - instruction-cycle numbers used by the poll window
//   - is_branch(): 1 when the opcode is a conditional branch
package interrupt_pkg;

  localparam logic [7:0] OP_BRK = 8'h00;
  localparam logic [7:0] OP_BPL = 8'h10;
  localparam logic [7:0] OP_BMI = 8'h30;
  localparam logic [7:0] OP_BVC = 8'h50;
  localparam logic [7:0] OP_BVS = 8'h70;
  localparam logic [7:0] OP_BCC = 8'h90;
  localparam logic [7:0] OP_BCS = 8'hB0;
  localparam logic [7:0] OP_BNE = 8'hD0;
  localparam logic [7:0] OP_BEQ = 8'hF0;

  // Instruction cycles that matter for interrupt polling
  localparam logic [2:0] CYC_T0 = 3'd0;
  localparam logic [2:0] CYC_T2 = 3'd2;

  function automatic logic is_branch(input logic [7:0] op);
    logic hit;
    case (op)
      OP_BPL, OP_BMI, OP_BVC, OP_BVS,
      OP_BCC, OP_BCS, OP_BNE, OP_BEQ: hit = 1'b1;
      default:                        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/interrupt_arbiter_source_cell.sv
// irq_source_cell
//   One interrupt source: input stage S, falling-edge or low-level detect,
//   and per-source acknowledge of a held edge event.
//   Ports:
//     clk_ph1  in   sole clock
//     rst      in   synchronous reset, active low
//     pin_n    in   source pin, active low
//     ack      in   clears a held edge event (ignored in level mode)
//     pending  out  registered pending bit
//   Parameter EDGE: 1 = falling-edge triggered, 0 = level (low) triggered.
module irq_source_cell #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk_ph1,
  input  logic rst,
  input  logic pin_n,
  input  logic ack,
  output logic pending
);

  logic s_reg;          // stage S sample of the pin
  logic s_last_reg;     // previous stage S sample
  logic s_valid_reg;    // s_reg holds a real pin sample
  logic last_valid_reg; // s_last_reg holds a real pin sample
  logic pend_reg;
  logic fall;
  logic pend_next;

  // The valid flags keep the reset value of the stage-S register from being
  // compared against the first real sample, so a pin held low through the
  // release of reset never looks like a falling edge.
  always_comb begin
    fall      = last_valid_reg & s_last_reg & ~s_reg;
    pend_next = ~s_reg;
    if (EDGE) begin
      // a new edge beats an acknowledge in the same cycle
      pend_next = fall | (pend_reg & ~ack);
    end
  end

  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      s_reg          <= 1'b1;
      s_last_reg     <= 1'b1;
      s_valid_reg    <= 1'b0;
      last_valid_reg <= 1'b0;
      pend_reg       <= 1'b0;
    end else begin
      s_reg          <= pin_n;
      s_last_reg     <= s_reg;
      s_valid_reg    <= 1'b1;
      last_valid_reg <= s_valid_reg;
      pend_reg       <= pend_next;
    end
  end

  assign pending = pend_reg;

endmodule

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter
//   Collects NUM_IRQ maskable sources plus one NMI, gates them with an
//   enable register and the CPU I flag, and raises irq_out / nmi_out only
//   in the CPU's interrupt-poll window.
//   Ports:
//     clk_ph1      in   sole clock
//     rst          in   synchronous reset, active low
//     irq_n        in   IRQ source pins, active low
//     nmi_n        in   NMI pin, active low, falling-edge triggered
//     irq_mask     in   CPU I flag, 1 blocks IRQ
//     en_wr        in   write strobe for the enable register
//     en_data      in   new enable value
//     irq_ack      in   per-source clear of edge-pending bits
//     irq_clr      in   CPU has taken the IRQ
//     nmi_clr      in   CPU has taken the NMI
//     cycle        in   current instruction cycle
//     next_cycle   in   next instruction cycle
//     IR           in   current opcode
//     irq_out      out  perform-IRQ request
//     nmi_out      out  perform-NMI request
//     irq_src      out  index of the source that caused irq_out
//     irq_pending  out  raw pending bits, before enable and mask
module interrupt_arbiter
  import interrupt_pkg::*;
#(
  parameter int                 NUM_IRQ   = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '0,
  parameter logic [NUM_IRQ-1:0] EN_RESET  = '1,
  localparam int                SRC_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk_ph1,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_n,
  input  logic               nmi_n,
  input  logic               irq_mask,
  input  logic               en_wr,
  input  logic [NUM_IRQ-1:0] en_data,
  input  logic [NUM_IRQ-1:0] irq_ack,
  input  logic               irq_clr,
  input  logic               nmi_clr,
  input  logic [2:0]         cycle,
  input  logic [2:0]         next_cycle,
  input  logic [7:0]         IR,
  output logic               irq_out,
  output logic               nmi_out,
  output logic [SRC_W-1:0]   irq_src,
  output logic [NUM_IRQ-1:0] irq_pending
);

  logic [NUM_IRQ-1:0] enable_reg;
  logic               irq_out_reg;
  logic               nmi_out_reg;
  logic [SRC_W-1:0]   irq_src_reg;
  logic [NUM_IRQ-1:0] req;
  logic [SRC_W-1:0]   low_idx;
  logic               nmi_pend;
  logic               branch;
  logic               poll;

  // Per-source detection
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
    irq_source_cell #(
      .EDGE (EDGE_MASK[gi])
    ) u_cell (
      .clk_ph1 (clk_ph1),
      .rst     (rst),
      .pin_n   (irq_n[gi]),
      .ack     (irq_ack[gi]),
      .pending (irq_pending[gi])
    );
  end

  // NMI is just an edge-mode source acknowledged by nmi_clr
  irq_source_cell #(
    .EDGE (1'b1)
  ) u_nmi_cell (
    .clk_ph1 (clk_ph1),
    .rst     (rst),
    .pin_n   (nmi_n),
    .ack     (nmi_clr),
    .pending (nmi_pend)
  );

  assign req = irq_pending & enable_reg & {NUM_IRQ{~irq_mask}};

  // Lowest set index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        low_idx = SRC_W'(i);
      end
    end
  end

  // Poll window: the last cycle of an instruction, except that a branch
  // polls at T2 instead of at the T0 that follows its T2. BRK never polls.
  always_comb begin
    branch = is_branch(IR);
    poll   = 1'b0;
    if (IR != OP_BRK) begin
      if ((next_cycle == CYC_T0) && !(branch && (cycle == CYC_T2))) begin
        poll = 1'b1;
      end else if ((next_cycle == CYC_T2) && branch) begin
        poll = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_ph1) begin
    if (!rst) begin
      enable_reg  <= EN_RESET;
      irq_out_reg <= 1'b0;
      irq_src_reg <= '0;
      nmi_out_reg <= 1'b0;
    end else begin
      if (en_wr) begin
        enable_reg <= en_data;
      end

      // irq_src only moves when a new request is latched
      if (irq_clr) begin
        irq_out_reg <= 1'b0;
      end else if (poll && (|req) && !irq_out_reg) begin
        irq_out_reg <= 1'b1;
        irq_src_reg <= low_idx;
      end

      if (nmi_clr) begin
        nmi_out_reg <= 1'b0;
      end else if (poll && nmi_pend) begin
        nmi_out_reg <= 1'b1;
      end
    end
  end

  assign irq_out = irq_out_reg;
  assign nmi_out = nmi_out_reg;
  assign irq_src = irq_src_reg;

endmodule

// File: tb/tb_interrupt_arbiter.sv
module tb_interrupt_arbiter;

  localparam int NUM_IRQ = 4;

  logic               clk_ph1 = 1'b0;
  logic               rst;
  logic [NUM_IRQ-1:0] irq_n;
  logic               nmi_n;
  logic               irq_mask;
  logic               en_wr;
  logic [NUM_IRQ-1:0] en_data;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               irq_clr;
  logic               nmi_clr;
  logic [2:0]         cycle;
  logic [2:0]         next_cycle;
  logic [7:0]         IR;
  logic               irq_out;
  logic               nmi_out;
  logic [1:0]         irq_src;
  logic [NUM_IRQ-1:0] irq_pending;

  int checks   = 0;
  int failures = 0;

  // scoreboard: expectation pushed when stimulus is driven, popped at check
  string       tag_q[$];
  logic [31:0] exp_q[$];

  interrupt_arbiter #(
    .NUM_IRQ   (NUM_IRQ),
    .EDGE_MASK (4'b1000),
    .EN_RESET  (4'b1111)
  ) dut (
    .clk_ph1     (clk_ph1),
    .rst         (rst),
    .irq_n       (irq_n),
    .nmi_n       (nmi_n),
    .irq_mask    (irq_mask),
    .en_wr       (en_wr),
    .en_data     (en_data),
    .irq_ack     (irq_ack),
    .irq_clr     (irq_clr),
    .nmi_clr     (nmi_clr),
    .cycle       (cycle),
    .next_cycle  (next_cycle),
    .IR          (IR),
    .irq_out     (irq_out),
    .nmi_out     (nmi_out),
    .irq_src     (irq_src),
    .irq_pending (irq_pending)
  );

  always #5 clk_ph1 = ~clk_ph1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_ph1);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty: observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic poll_on();
    IR = 8'hEA; cycle = 3'd1; next_cycle = 3'd0;
  endtask

  task automatic poll_off();
    IR = 8'hEA; cycle = 3'd1; next_cycle = 3'd1;
  endtask

  initial begin
    rst = 1'b0; irq_n = '1; nmi_n = 1'b1; irq_mask = 1'b0;
    en_wr = 1'b0; en_data = '0; irq_ack = '0;
    irq_clr = 1'b0; nmi_clr = 1'b0;
    poll_off();

    // reset state
    tick(); tick();
    expect_val("rst_irq_out", 0);     check(irq_out);
    expect_val("rst_nmi_out", 0);     check(nmi_out);
    expect_val("rst_irq_src", 0);     check(irq_src);
    expect_val("rst_pending", 0);     check(irq_pending);
    rst = 1'b1;
    tick(); tick();

    // priority: sources 1 and 3 low, lowest index wins
    irq_n = 4'b0101;
    tick(); tick();
    expect_val("prio_pending", 4'b1010); check(irq_pending);
    poll_on();
    tick();
    expect_val("prio_irq_out", 1); check(irq_out);
    expect_val("prio_irq_src", 1); check(irq_src);
    poll_off(); irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    expect_val("prio_clr", 0); check(irq_out);
    irq_n = '1; irq_ack = 4'b1000;
    tick(); tick();
    irq_ack = '0;
    expect_val("prio_idle_pending", 0); check(irq_pending);

    // edge source: one-cycle pulse is held
    irq_n = 4'b0111;
    tick();
    irq_n = '1;
    tick(); tick(); tick();
    expect_val("edge_held", 4'b1000); check(irq_pending);
    poll_on();
    tick();
    expect_val("edge_irq_out", 1); check(irq_out);
    expect_val("edge_irq_src", 3); check(irq_src);
    // request drops but irq_out/irq_src hold until irq_clr
    poll_off(); irq_ack = 4'b1000;
    tick();
    irq_ack = '0;
    tick(); tick();
    expect_val("hold_pending", 0); check(irq_pending);
    expect_val("hold_irq_out", 1); check(irq_out);
    expect_val("hold_irq_src", 3); check(irq_src);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    expect_val("hold_clr", 0); check(irq_out);
    // new edge and ack in the same cycle: set wins
    irq_n = 4'b0111;
    tick();
    irq_ack = 4'b1000;
    tick();
    irq_ack = '0; irq_n = '1;
    tick();
    expect_val("edge_set_vs_ack", 4'b1000); check(irq_pending);
    irq_ack = 4'b1000;
    tick();
    irq_ack = '0;
    expect_val("edge_ack_clears", 0); check(irq_pending);

    // level source ignores ack
    irq_n = 4'b1110;
    tick(); tick();
    expect_val("level_pending", 4'b0001); check(irq_pending);
    irq_ack = 4'b0001;
    tick();
    irq_ack = '0;
    expect_val("level_ack_ignored", 4'b0001); check(irq_pending);

    // mask and enable
    irq_mask = 1'b1; poll_on();
    tick(); tick();
    expect_val("mask_blocks", 0); check(irq_out);
    poll_off(); irq_mask = 1'b0; en_wr = 1'b1; en_data = '0;
    tick();
    en_wr = 1'b0; poll_on();
    tick(); tick();
    expect_val("enable_blocks", 0); check(irq_out);
    expect_val("enable_raw_pending", 4'b0001); check(irq_pending);
    en_wr = 1'b1; en_data = '1;
    tick();
    en_wr = 1'b0;
    expect_val("enable_next_cycle", 0); check(irq_out);
    tick();
    expect_val("enable_fires", 1); check(irq_out);
    expect_val("enable_src", 0); check(irq_src);
    // clear on a poll edge wins
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0; poll_off(); irq_n = '1;
    expect_val("clr_beats_poll", 0); check(irq_out);
    tick(); tick();

    // NMI: branch gating
    nmi_n = 1'b0;
    tick(); tick();
    nmi_n = 1'b1;
    IR = 8'hD0; cycle = 3'd2; next_cycle = 3'd0;
    tick(); tick();
    expect_val("nmi_branch_t2_t0", 0); check(nmi_out);
    next_cycle = 3'd2;
    tick();
    expect_val("nmi_branch_poll", 1); check(nmi_out);
    poll_off(); nmi_clr = 1'b1;
    tick();
    nmi_clr = 1'b0;
    expect_val("nmi_clr", 0); check(nmi_out);
    // BRK never polls
    nmi_n = 1'b0;
    tick(); tick();
    nmi_n = 1'b1;
    IR = 8'h00; cycle = 3'd1; next_cycle = 3'd0;
    tick(); tick();
    expect_val("nmi_brk_no_poll", 0); check(nmi_out);
    poll_on();
    tick();
    expect_val("nmi_after_brk", 1); check(nmi_out);
    poll_off(); nmi_clr = 1'b1;
    tick();
    nmi_clr = 1'b0;
    // NMI edge and nmi_clr in the same cycle: pending survives
    nmi_n = 1'b0;
    tick();
    nmi_clr = 1'b1;
    tick();
    nmi_clr = 1'b0; nmi_n = 1'b1;
    tick();
    expect_val("nmi_set_vs_clr_out", 0); check(nmi_out);
    poll_on();
    tick();
    expect_val("nmi_set_vs_clr_pend", 1); check(nmi_out);
    poll_off(); nmi_clr = 1'b1;
    tick();
    nmi_clr = 1'b0;

    // reset mid-request, pins held low through release
    irq_n = 4'b1110; nmi_n = 1'b0; poll_on();
    tick(); tick(); tick();
    expect_val("pre_rst_irq_out", 1); check(irq_out);
    expect_val("pre_rst_nmi_out", 1); check(nmi_out);
    rst = 1'b0;
    tick();
    expect_val("rst_drop_irq", 0); check(irq_out);
    expect_val("rst_drop_nmi", 0); check(nmi_out);
    tick();
    rst = 1'b1;
    tick();
    expect_val("release_pending_e1", 0); check(irq_pending);
    tick();
    expect_val("release_pending_e2", 4'b0001); check(irq_pending);
    tick(); tick(); tick(); tick(); tick();
    expect_val("release_no_nmi", 0); check(nmi_out);
    expect_val("release_irq_out", 1); check(irq_out);

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 SHALL provide parameter NUM_IRQ, default 4: number of maskable IRQ sources (1..8).
REQ-002 SHALL provide parameter EDGE_MASK [NUM_IRQ-1:0], default 0: bit i = 1 makes source i falling-edge triggered; bit i = 0 makes it level (low) triggered.
REQ-003 SHALL provide parameter EN_RESET [NUM_IRQ-1:0], default all ones: reset value of the enable register.
REQ-004 SHALL use one clock and a synchronous active-low reset: all sequential logic runs on the single clock clk_ph1, and reset is rst, sampled on that edge only.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- clk_ph1  in  1  sole clock
- rst  in  1  synchronous reset, active low
- irq_n  in  NUM_IRQ  IRQ source pins, active low
- nmi_n  in  1  NMI pin, active low, edge triggered
- irq_mask  in  1  CPU I flag; 1 blocks IRQ
- en_wr  in  1  write strobe for the enable register
- en_data  in  NUM_IRQ  new enable value
- irq_ack  in  NUM_IRQ  per-source clear of edge-pending bits
- irq_clr  in  1  CPU has taken the IRQ
- nmi_clr  in  1  CPU has taken the NMI
- cycle  in  3  current instruction cycle
- next_cycle  in  3  next instruction cycle
- IR  in  8  current opcode
- irq_out  out  1  perform-IRQ request
- nmi_out  out  1  perform-NMI request
- irq_src  out  clog2(NUM_IRQ) (min 1)  index of the source that caused irq_out
- irq_pending  out  NUM_IRQ  raw pending bits, before enable and mask

Function
REQ-006 SHALL register irq_n and nmi_n once (stage S) on every clk_ph1 edge; all detection uses the stage-S values only.
REQ-007 SHALL make a level source pending whenever its stage-S value is 0; the bit is recomputed every cycle and is not sticky.
REQ-008 SHALL set an edge source's pending bit on a stage-S 1->0 transition and hold it until the matching irq_ack bit is seen; a set and an ack in the same cycle SHALL leave the bit set.
REQ-009 SHALL ignore irq_ack bits that belong to level sources.
REQ-010 SHALL set nmi_pend on a stage-S nmi 1->0 transition, hold it until nmi_clr, and give a set precedence over a simultaneous nmi_clr.
REQ-011 SHALL compute req = irq_pending & enable & {NUM_IRQ{!irq_mask}}.
REQ-012 SHALL load the enable register from en_data on en_wr; a new enable value SHALL affect req from the next cycle.
REQ-013 SHALL raise poll when both hold:
- IR != 0x00 (BRK), and
- either next_cycle == 0 and not (branch and cycle == 2), or next_cycle == 2 and branch.
branch means IR is one of 0x10, 0x30, 0x50, 0x70, 0x90, 0xB0, 0xD0, 0xF0.
REQ-014 On a poll edge with |req and irq_out == 0, SHALL set irq_out = 1 and latch irq_src = lowest set index of req.
REQ-015 irq_out and irq_src SHALL then hold until irq_clr, even if req drops.
REQ-016 On a poll edge with nmi_pend == 1, SHALL set nmi_out = 1; nmi_out SHALL hold until nmi_clr.
REQ-017 irq_clr SHALL clear irq_out only; nmi_clr SHALL clear nmi_out and nmi_pend only.
REQ-018 When a clear and a poll occur in the same cycle, the clear SHALL win for that output.
REQ-019 nmi_out and irq_out MAY be high together; the CPU prioritises NMI, and the block takes no further action.
REQ-020 Latency: a pin going low before edge E0 is captured at E0 and becomes pending at E1; the output SHALL assert at the first poll edge at or after E2.

Reset
REQ-021 While rst == 0 at a clk_ph1 edge, SHALL set: irq_out = 0, nmi_out = 0, irq_src = 0, pending = 0, nmi_pend = 0, stage-S registers = 1 (inactive), enable = EN_RESET.
REQ-022 Reset asserted in mid-request SHALL drop irq_out and nmi_out on that edge.
REQ-023 A pin held low through the release of reset SHALL NOT generate an edge event; a level source SHALL become pending 2 edges after release.

Structure
REQ-024 SHALL take from package interrupt_pkg: the opcode constants (BRK and the 8 branches) and an is_branch function.
REQ-025 SHALL implement one sub-module, irq_source_cell (stage S, edge/level detect, ack), instantiated NUM_IRQ times by generate.

Verification
REQ-026 Priority: NUM_IRQ = 4, level; irq_n = 4'b0101 held; poll pulse -> irq_out = 1, irq_src = 1; irq_clr -> irq_out = 0.
REQ-027 Edge hold and ack: EDGE_MASK = 4'b1000; pulse irq_n[3] low 1 cycle -> irq_pending[3] stays 1 after the pulse; poll gives irq_src = 3; irq_ack[3] together with a new edge -> bit stays 1.
REQ-028 Branch and BRK gating:
- IR = 0xD0, cycle = 2, next_cycle = 0 with an NMI pending -> nmi_out stays 0.
- next_cycle = 2 -> nmi_out = 1.
- IR = 0x00 -> no poll.
REQ-029 Mask and enable: irq_mask = 1 -> no irq_out; en_wr with en_data = 0 and irq_mask = 0 -> no irq_out, while irq_pending still shows the source.
REQ-030 Simultaneous events: irq_clr on a poll edge -> irq_out = 0; NMI edge plus nmi_clr in one cycle -> nmi_pend = 1.
REQ-031 Reset: rst low while irq_out = 1 -> outputs 0 next edge; nmi_n held low across release -> nmi_out never asserts.
